// File: rtl/ldpc_dec_ctrl_pkg.sv
// Shared types and width helpers for the LDPC frame sequencer.
package ldpc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CNU,
        S_VNU,
        S_CHK,
        S_UNLOAD
    } state_t;

    function automatic int sw_f(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

    function automatic int iw_f(input int max_iter);
        return $clog2(max_iter + 1);
    endfunction

    function automatic int aw_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int tbl_idx(input int i, input int j, input int r);
        return i * r + j;
    endfunction

endpackage

// File: rtl/ldpc_dec_ctrl_syndrome.sv
// Combinational parity checker: one bit per check row/circulant position.
module ldpc_syndrome
    import ldpc_pkg::*;
#(
    parameter int R = 5,
    parameter int C = 3,
    parameter int D = 8
) (
    input  logic [R*D-1:0]           dec,
    input  logic [C*R*sw_f(D)-1:0]   shift,
    output logic [C*D-1:0]           syn,
    output logic                     syn_zero
);
    localparam int SW = sw_f(D);

    always_comb begin
        syn = '0;
        for (int i = 0; i < C; i++) begin
            for (int k = 0; k < D; k++) begin
                for (int j = 0; j < R; j++) begin
                    syn[i*D+k] = syn[i*D+k] ^
                        dec[j*D + ((k + int'(shift[tbl_idx(i, j, R)*SW +: SW])) % D)];
                end
            end
        end
    end

    assign syn_zero = ~|syn;

endmodule

// File: rtl/ldpc_dec_ctrl.sv
// LDPC decoder frame sequencer: load, CNU/VNU phasing, syndrome check, unload.
// LDPC_EARLY_TERM_EN enables exit on the first zero syndrome.
module ldpc_dec_ctrl
    import ldpc_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int R        = 5,
    parameter int C        = 3,
    parameter int D        = 8,
    parameter int MAX_ITER = 10,
    parameter int PH_LAT   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_we,
    input  logic [aw_f(C*R)-1:0]        cfg_addr,
    input  logic [sw_f(D)-1:0]          cfg_shift,
    input  logic                        llr_valid,
    output logic                        llr_ready,
    input  logic [DATA_W*D-1:0]         llr_data,
    output logic [DATA_W*R*D-1:0]       llr_bus,
    output logic                        cnu_en,
    output logic                        vnu_en,
    input  logic [R*D-1:0]              dec_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [D-1:0]                out_data,
    output logic [iw_f(MAX_ITER)-1:0]   out_iter,
    output logic                        out_pass,
    output logic                        busy
);
    localparam int SW = sw_f(D);
    localparam int IW = iw_f(MAX_ITER);
    localparam int NT = C * R;
    localparam int CW = (R > 1) ? $clog2(R) : 1;
    localparam int PW = (PH_LAT > 1) ? $clog2(PH_LAT) : 1;

    state_t                  state_q, state_d;
    logic [CW-1:0]           col_q, col_d;
    logic [PW-1:0]           ph_q, ph_d;
    logic [IW-1:0]           iter_q, iter_d;
    logic                    pass_q, pass_d;
    logic [DATA_W*R*D-1:0]   llr_bus_q, llr_bus_d;
    logic [R*D-1:0]          snap_q, snap_d;
    logic [NT*SW-1:0]        shift_q, shift_d;
    logic                    llr_ready_q, llr_ready_d;
    logic                    cnu_en_q, cnu_en_d;
    logic                    vnu_en_q, vnu_en_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;

    logic [C*D-1:0]          syn;
    logic                    syn_zero;
    logic                    chk_zero;
    logic                    accept;
    logic                    hs;

    ldpc_syndrome #(.R(R), .C(C), .D(D)) u_syn (
        .dec      (dec_in),
        .shift    (shift_q),
        .syn      (syn),
        .syn_zero (syn_zero)
    );

    assign chk_zero = syn_zero && (syn == '0);
    assign accept   = llr_valid && llr_ready_q;
    assign hs       = out_valid_q && out_ready;

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        ph_d      = ph_q;
        iter_d    = iter_q;
        pass_d    = pass_q;
        llr_bus_d = llr_bus_q;
        snap_d    = snap_q;
        shift_d   = shift_q;

        // Table writes only while idle, so a running frame never sees a torn table.
        if (state_q == S_IDLE && cfg_we && int'(cfg_shift) < D && int'(cfg_addr) < NT)
            shift_d[int'(cfg_addr)*SW +: SW] = cfg_shift;

        case (state_q)
            S_IDLE, S_LOAD: begin
                if (accept) begin
                    llr_bus_d[int'(col_q)*DATA_W*D +: DATA_W*D] = llr_data;
                    if (col_q == CW'(R-1)) begin
                        state_d = S_CNU;
                        col_d   = '0;
                        ph_d    = '0;
                        iter_d  = '0;
                    end else begin
                        state_d = S_LOAD;
                        col_d   = col_q + CW'(1);
                    end
                end
            end
            S_CNU: begin
                if (ph_q == PW'(PH_LAT-1)) begin
                    ph_d    = '0;
                    state_d = S_VNU;
                    iter_d  = iter_q + IW'(1);
                end else begin
                    ph_d = ph_q + PW'(1);
                end
            end
            S_VNU: begin
                if (ph_q == PW'(PH_LAT-1)) begin
                    ph_d    = '0;
                    state_d = S_CHK;
                end else begin
                    ph_d = ph_q + PW'(1);
                end
            end
            S_CHK: begin
                snap_d = dec_in;
                col_d  = '0;
`ifdef LDPC_EARLY_TERM_EN
                if (chk_zero) begin
                    pass_d  = 1'b1;
                    state_d = S_UNLOAD;
                end else if (iter_q == IW'(MAX_ITER)) begin
                    pass_d  = 1'b0;
                    state_d = S_UNLOAD;
                end else begin
                    state_d = S_CNU;
                end
`else
                if (iter_q == IW'(MAX_ITER)) begin
                    pass_d  = chk_zero;
                    state_d = S_UNLOAD;
                end else begin
                    state_d = S_CNU;
                end
`endif
            end
            S_UNLOAD: begin
                if (hs) begin
                    if (col_q == CW'(R-1)) begin
                        state_d = S_IDLE;
                        col_d   = '0;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        llr_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
        cnu_en_d    = (state_d == S_CNU);
        vnu_en_d    = (state_d == S_VNU);
        out_valid_d = (state_d == S_UNLOAD);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            ph_q        <= '0;
            iter_q      <= '0;
            pass_q      <= 1'b0;
            llr_bus_q   <= '0;
            snap_q      <= '0;
            shift_q     <= '0;
            llr_ready_q <= 1'b0;
            cnu_en_q    <= 1'b0;
            vnu_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            ph_q        <= ph_d;
            iter_q      <= iter_d;
            pass_q      <= pass_d;
            llr_bus_q   <= llr_bus_d;
            snap_q      <= snap_d;
            shift_q     <= shift_d;
            llr_ready_q <= llr_ready_d;
            cnu_en_q    <= cnu_en_d;
            vnu_en_q    <= vnu_en_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign llr_ready = llr_ready_q;
    assign llr_bus   = llr_bus_q;
    assign cnu_en    = cnu_en_q;
    assign vnu_en    = vnu_en_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? snap_q[int'(col_q)*D +: D] : '0;
    assign out_iter  = iter_q;
    assign out_pass  = pass_q;
    assign busy      = busy_q;

endmodule

// File: doc/ldpc_dec_ctrl.md
Name: ldpc_dec_ctrl

Overview:
- Frame sequencer for the quasi-cyclic LDPC decoder fabric: buffers one channel-LLR frame, drives CNU/VNU phase enables, checks the syndrome after every VNU phase, and streams out hard decisions.
- Parametrised in block-rows, block-columns, circulant size and iteration count.
- The per-circulant shift table is runtime-loadable instead of fixed.
- Sits between the frame input stream and the cnu/vnu/cyc_shift array; the array datapath is untouched.

Parameters:
- DATA_W, 8, LLR width in bits (two's complement).
- R, 5, block columns (variable groups).
- C, 3, block rows (check groups).
- D, 8, circulant size.
- MAX_ITER, 10, maximum decoding iterations (at least 1).
- PH_LAT, 2, cycles each CNU or VNU phase enable is held (at least 1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- cfg_we  in  1  shift-table write strobe.
- cfg_addr  in  clog2(C*R)  table index, computed as i*R+j.
- cfg_shift  in  SW=max(1,clog2(D))  circulant shift value.
- llr_valid  in  1  input beat valid.
- llr_ready  out  1  input beat accepted.
- llr_data  in  DATA_W*D  one block column of LLRs, element k at [k*DATA_W +: DATA_W].
- llr_bus  out  DATA_W*R*D  frame LLRs to the VNU array.
- cnu_en  out  1  CNU phase enable.
- vnu_en  out  1  VNU phase enable.
- dec_in  in  R*D  hard decisions from the VNU array.
- out_valid  out  1  output beat valid.
- out_ready  in  1  output beat taken.
- out_data  out  D  one block column of decisions.
- out_iter  out  clog2(MAX_ITER+1)  iterations used.
- out_pass  out  1  syndrome was zero.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0; llr_bus and the frame buffer clear to 0.
  - Shift table clears to 0.
  - Reset applies mid-frame from any state; any partial frame is discarded.
- States: IDLE, LOAD, CNU, VNU, CHK, UNLOAD.
- IDLE:
  - llr_ready=1.
  - The first accepted beat is stored as column 0 and the state moves to LOAD.
- LOAD:
  - llr_ready=1.
  - Beats fill columns 1..R-1.
  - The accept of beat R-1 moves to CNU with iter=0.
  - Gaps in llr_valid stall without loss.
- CNU:
  - cnu_en=1 for exactly PH_LAT cycles, then VNU.
- VNU:
  - vnu_en=1 for PH_LAT cycles, then CHK; iter increments on entry.
- CHK (1 cycle):
  - syn[i*D+k] = XOR over j of dec_in[j*D + (k+shift[i][j]) mod D], for all C*D checks.
  - If syn is all zero, pass=1 and go to UNLOAD.
  - Else if iter==MAX_ITER, pass=0 and go to UNLOAD.
  - Else go to CNU.
  - dec_in is sampled only in this state.
- UNLOAD:
  - dec_in snapshot taken in CHK.
  - out_valid=1; out_data = columns 0..R-1 in order.
  - Advance only on out_valid&&out_ready.
  - out_iter and out_pass are constant across all R beats.
  - After the last beat, go to IDLE with out_valid=0 the next cycle.
  - Backpressure may hold a beat indefinitely.
- llr_ready is 0 in CNU, VNU, CHK and UNLOAD.
- There is no overlap of consecutive frames.
- llr_bus is constant from LOAD completion until the next frame starts loading.
- Shift table:
  - A write is accepted only in IDLE.
  - A write in any other state is ignored.
  - A write with cfg_shift>=D or cfg_addr>=C*R is ignored.
  - If cfg_we and the first llr beat occur in the same IDLE cycle, both take effect; the new shift applies to that frame.
- Minimum frame latency is R + MAX_ITER-bounded (2*PH_LAT+1)*iter + R cycles.

Optional Feature:
- LDPC_EARLY_TERM_EN:
  - Defined: CHK exits on zero syndrome as above.
  - Undefined: CHK always loops until iter==MAX_ITER. out_pass still reflects the final syndrome, and out_iter always equals MAX_ITER.

Decomposition:
- Package ldpc_pkg holds:
  - state enum
  - width functions (clog2-based SW, IW)
  - shift-table index helper i*R+j
- Sub-module ldpc_syndrome:
  - combinational checker of C*D parity bits
  - inputs: dec vector and flattened shift table
  - outputs: syn and syn_zero

Test Plan:
- Default params, all shifts 0, LLR frame with all +10, dec_in driven all 0 -> CHK at iter=1, out_pass=1, out_iter=1, 5 beats of out_data=8'h00.
- All shifts 0, dec_in has a single 1 at bit 3 -> syndrome nonzero every CHK, runs 10 iterations, out_pass=0, out_iter=10.
- Shift[0][0]=3, dec_in bit j*D+k pattern satisfying parity only under shift 3 -> out_pass=1. Rewrite to 2 -> out_pass=0. cfg_we during CNU is ignored, so the result is unchanged.
- out_ready held low 20 cycles on beat 2 -> out_data and out_valid stable, no beat dropped, exactly 5 handshakes total.
- rst=0 in VNU of iteration 4 -> next cycle busy=0, cnu_en=vnu_en=out_valid=0, shift table 0; a new frame then completes normally.
- LDPC_EARLY_TERM_EN undefined with a zero-syndrome frame -> out_iter=10, out_pass=1.
